// File: rtl/de2_70_nios_ocimem_ctrl_pkg.sv
// de2_70_nios_ocimem_ctrl_pkg: jdo field positions, FSM encodings and JTAG command codes
package de2_70_nios_ocimem_ctrl_pkg;
  localparam int RD_BIT     = 34;
  localparam int CLRERR_BIT = 33;
  localparam int DATA_MSB   = 31;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_JRD     = 3'd1;
  localparam logic [2:0] S_JRDCAP  = 3'd2;
  localparam logic [2:0] S_JWR     = 3'd3;
  localparam logic [2:0] S_AVRD    = 3'd4;
  localparam logic [2:0] S_AVRDONE = 3'd5;
  localparam logic [2:0] S_AVWR    = 3'd6;
  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_RD    = 2'd1;
  localparam logic [1:0] CMD_RDINC = 2'd2;
  localparam logic [1:0] CMD_WR    = 2'd3;
  function automatic logic [1:0] pulse_cmd(input logic a, input logic na, input logic b);
    return b ? CMD_WR : a ? CMD_RD : na ? CMD_RDINC : CMD_NONE;
  endfunction
  function automatic logic is_rw(input logic [1:0] cmd, input logic [37:0] d);
    return cmd == CMD_WR || cmd == CMD_RDINC || (cmd == CMD_RD && d[RD_BIT]);
  endfunction
endpackage

// File: rtl/de2_70_nios_ocimem_ram.sv
// de2_70_nios_ocimem_ram: single-port debug RAM, 1-cycle synchronous read, byte-enable write
module de2_70_nios_ocimem_ram #(
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       d,
  output logic [31:0]       q
);
  logic [31:0] r_mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < 4; i++)
        if (be[i]) r_mem[addr][8*i +: 8] <= d[8*i +: 8];
    q <= r_mem[addr];
  end
endmodule

// File: rtl/de2_70_nios_ocimem_ctrl.sv
// de2_70_nios_ocimem_ctrl: arbitrates JTAG debug commands and a CPU Avalon slave onto one debug RAM
module de2_70_nios_ocimem_ctrl
  import de2_70_nios_ocimem_ctrl_pkg::*;
#(
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  input  logic [3:0]        av_byteenable,
  input  logic              av_debugaccess,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);
  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_mon_a;
  logic [31:0]       r_wdata;
  logic              r_pend_v;
  logic [1:0]        r_pend_cmd;
  logic [37:0]       r_pend_jdo;
  logic [1:0]        w_cmd;
  logic              w_pulse, w_multi, w_idle, w_latch, w_drop, w_exec, w_unused;
  logic [1:0]        w_exec_cmd;
  logic [37:0]       w_exec_jdo;
  logic [ADDR_W-1:0] w_addr;
  logic              w_we, w_av_side;
  logic [3:0]        w_be;
  logic [31:0]       w_d, w_q;
  assign w_cmd      = pulse_cmd(take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b);
  assign w_pulse    = w_cmd != CMD_NONE;
  assign w_multi    = (take_action_ocimem_a & take_no_action_ocimem_a) |
                      (take_action_ocimem_a & take_action_ocimem_b) |
                      (take_no_action_ocimem_a & take_action_ocimem_b);
  assign w_idle     = r_state == S_IDLE;
  assign w_exec_cmd = r_pend_v ? r_pend_cmd : w_cmd;
  assign w_exec_jdo = r_pend_v ? r_pend_jdo : jdo;
  assign w_exec     = w_idle && w_exec_cmd != CMD_NONE;
  assign w_latch    = w_pulse && (w_idle ? r_pend_v : !r_pend_v);
  assign w_drop     = w_pulse && !w_idle && r_pend_v;
  assign w_unused   = ^{w_exec_jdo[37:35], w_exec_jdo[32]};
  assign w_av_side  = r_state == S_AVRD || r_state == S_AVWR;
  assign w_addr     = w_av_side ? av_address : r_mon_a;
  assign w_we       = reset_n && (r_state == S_JWR || (r_state == S_AVWR && av_debugaccess));
  assign w_be       = r_state == S_AVWR ? av_byteenable : 4'hF;
  assign w_d        = r_state == S_AVWR ? av_writedata : r_wdata;
  assign av_waitrequest = !(r_state == S_AVRDONE || r_state == S_AVWR);
  assign av_readdata    = r_state == S_AVRDONE ? w_q : 32'h0;
  de2_70_nios_ocimem_ram #(.ADDR_W(ADDR_W), .INIT_FILE(INIT_FILE)) u_ram (
    .clk(clk), .addr(w_addr), .we(w_we), .be(w_be), .d(w_d), .q(w_q)
  );
  // command sequencing, 1-deep JTAG pending slot and monitor status registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_mon_a       <= '0;
      r_wdata       <= '0;
      r_pend_v      <= 1'b0;
      r_pend_cmd    <= CMD_NONE;
      r_pend_jdo    <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      if (w_latch) begin
        r_pend_cmd <= w_cmd;
        r_pend_jdo <= jdo;
      end
      r_pend_v <= w_latch | (r_pend_v & !w_idle);
      if (w_exec && w_exec_cmd == CMD_RD && w_exec_jdo[CLRERR_BIT]) monitor_error <= 1'b0;
      if (w_drop || (w_pulse && w_multi)) monitor_error <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_exec) begin
            if (w_exec_cmd == CMD_RD) begin
              r_mon_a <= w_exec_jdo[ADDR_W+1:2];
              if (w_exec_jdo[RD_BIT]) r_state <= S_JRD;
            end else if (w_exec_cmd == CMD_RDINC) begin
              r_mon_a <= r_mon_a + 1'b1;
              r_state <= S_JRD;
            end else begin
              r_wdata <= w_exec_jdo[DATA_MSB:0];
              r_state <= S_JWR;
            end
          end else if (av_read) r_state <= S_AVRD;
          else if (av_write) r_state <= S_AVWR;
        end
        S_JRD: r_state <= S_JRDCAP;
        S_JRDCAP: begin
          MonDReg       <= w_q;
          monitor_ready <= !(r_pend_v && is_rw(r_pend_cmd, r_pend_jdo));
          r_state       <= S_IDLE;
        end
        S_JWR: begin
          r_mon_a       <= r_mon_a + 1'b1;
          monitor_ready <= !(r_pend_v && is_rw(r_pend_cmd, r_pend_jdo));
          r_state       <= S_IDLE;
        end
        S_AVRD: r_state <= S_AVRDONE;
        default: r_state <= S_IDLE;
      endcase
      if (w_pulse && is_rw(w_cmd, jdo)) monitor_ready <= 1'b0;
    end
  end
endmodule
